// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_pkg
// Brief    : Shared types and defaults for the data memory arbiter.
// Revision : 1.0
// ============================================================================
package data_mem_pkg;

    localparam int c_addr_w = 8;
    localparam int c_data_w = 8;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2
    } lock_state_e;

endpackage
`default_nettype wire

// File: rtl/data_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter_if
// Brief    : Request ports A/B plus the memory-side bus of the arbiter.
// Revision : 1.0
// ============================================================================
interface data_mem_arbiter_if
    import data_mem_pkg::*;
#(
    parameter int ADDR_W = c_addr_w,
    parameter int DATA_W = c_data_w
);
    logic              a_req,    b_req;
    logic              a_we,     b_we;
    logic              a_lock,   b_lock;
    logic [ADDR_W-1:0] a_addr,   b_addr;
    logic [DATA_W-1:0] a_wdata,  b_wdata;
    logic              a_gnt,    b_gnt;
    logic              a_rvalid, b_rvalid;
    logic [DATA_W-1:0] a_rdata,  b_rdata;
    logic              en_drd;
    logic              en_dwr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    // Arbiter side.
    modport slave (
        input  a_req, a_we, a_lock, a_addr, a_wdata,
        input  b_req, b_we, b_lock, b_addr, b_wdata,
        input  mem_dout,
        output a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
        output en_drd, en_dwr, mem_addr, mem_din
    );

    // Requesters and memory side.
    modport master (
        output a_req, a_we, a_lock, a_addr, a_wdata,
        output b_req, b_we, b_lock, b_addr, b_wdata,
        output mem_dout,
        input  a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
        input  en_drd, en_dwr, mem_addr, mem_din
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick2
// Brief    : Two-request round-robin picker; one-hot grant {B, A}.
// Revision : 1.0
// ============================================================================
module rr_pick2
    import data_mem_pkg::*;
(
    input  wire logic       i_req_a,
    input  wire logic       i_req_b,
    input  wire port_e      i_last,
    output logic      [1:0] o_gnt
);

    always_comb begin
        o_gnt = {i_req_b, i_req_a};
        // On contention the port that was not served last wins.
        if (i_req_a && i_req_b) begin
            o_gnt = (i_last == PORT_B) ? 2'b01 : 2'b10;
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter
// Brief    : Shares a single-port sync data memory between ports A and B.
// Revision : 1.0
// ============================================================================
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int ADDR_W   = c_addr_w,
    parameter int DATA_W   = c_data_w,
    parameter int LOCK_MAX = 4
) (
    input wire logic          clk,
    input wire logic          rst_n,
    data_mem_arbiter_if.slave bus
);

    localparam logic [3:0] c_lock_max = 4'(LOCK_MAX);

    lock_state_e       r_state_q,       w_state_d;
    logic [3:0]        r_lock_cnt_q,    w_lock_cnt_d;
    port_e             r_last_q,        w_last_d;
    logic              r_rd_tag_v_q,    w_rd_tag_v_d;
    port_e             r_rd_tag_port_q, w_rd_tag_port_d;

    logic [1:0]        w_rr_gnt;
    logic [1:0]        w_gnt;
    logic              w_any_gnt;
    port_e             w_gnt_port;
    logic              w_gnt_we;
    logic              w_gnt_lock;
    logic              w_owner_match;
    logic [3:0]        w_cnt_inc;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_din;

    rr_pick2 u_rr_pick2 (
        .i_req_a (bus.a_req),
        .i_req_b (bus.b_req),
        .i_last  (r_last_q),
        .o_gnt   (w_rr_gnt)
    );

    always_comb begin
        w_gnt = w_rr_gnt;
        if (r_state_q == ST_OWN_A && bus.a_req) begin
            w_gnt = 2'b01;
        end else if (r_state_q == ST_OWN_B && bus.b_req) begin
            w_gnt = 2'b10;
        end
        if (!rst_n) begin
            w_gnt = 2'b00;
        end
    end

    assign w_any_gnt  = |w_gnt;
    assign w_gnt_port = w_gnt[1] ? PORT_B : PORT_A;
    assign w_gnt_we   = w_gnt[1] ? bus.b_we   : bus.a_we;
    assign w_gnt_lock = w_gnt[1] ? bus.b_lock : bus.a_lock;
    assign w_mem_addr = w_gnt[1] ? bus.b_addr  : bus.a_addr;
    assign w_mem_din  = w_gnt[1] ? bus.b_wdata : bus.a_wdata;

    assign bus.a_gnt    = w_gnt[0];
    assign bus.b_gnt    = w_gnt[1];
    assign bus.en_dwr   = w_any_gnt &  w_gnt_we;
    assign bus.en_drd   = w_any_gnt & ~w_gnt_we;
    assign bus.mem_addr = w_mem_addr;
    assign bus.mem_din  = w_mem_din;

    // Counting continues only while the same owner keeps its lock.
    assign w_owner_match = (w_gnt_port == PORT_A && r_state_q == ST_OWN_A) ||
                           (w_gnt_port == PORT_B && r_state_q == ST_OWN_B);
    assign w_cnt_inc     = (w_owner_match ? r_lock_cnt_q : 4'd0) + 4'd1;

    always_comb begin
        w_state_d       = ST_IDLE;
        w_lock_cnt_d    = 4'd0;
        w_last_d        = r_last_q;
        w_rd_tag_v_d    = w_any_gnt & ~w_gnt_we;
        w_rd_tag_port_d = w_gnt_port;
        if (w_any_gnt) begin
            w_last_d = w_gnt_port;
            // Hitting the bound drops to IDLE with last = owner, handing off.
            if (w_gnt_lock && (w_cnt_inc < c_lock_max)) begin
                w_state_d    = (w_gnt_port == PORT_A) ? ST_OWN_A : ST_OWN_B;
                w_lock_cnt_d = w_cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q       <= ST_IDLE;
            r_lock_cnt_q    <= 4'd0;
            r_last_q        <= PORT_B;
            r_rd_tag_v_q    <= 1'b0;
            r_rd_tag_port_q <= PORT_A;
        end else begin
            r_state_q       <= w_state_d;
            r_lock_cnt_q    <= w_lock_cnt_d;
            r_last_q        <= w_last_d;
            r_rd_tag_v_q    <= w_rd_tag_v_d;
            r_rd_tag_port_q <= w_rd_tag_port_d;
        end
    end

    assign bus.a_rvalid = r_rd_tag_v_q && (r_rd_tag_port_q == PORT_A);
    assign bus.b_rvalid = r_rd_tag_v_q && (r_rd_tag_port_q == PORT_B);
    assign bus.a_rdata  = bus.mem_dout;
    assign bus.b_rdata  = bus.mem_dout;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_arbiter
// Brief    : Scoreboard bench for data_mem_arbiter with a 256x8 memory model.
// Revision : 1.0
// ============================================================================
module tb_data_mem_arbiter;

    logic clk;
    logic rst_n;

    data_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    data_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .LOCK_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [0:255];
    always @(posedge clk) begin
        if (bus.en_dwr) mem[bus.mem_addr] <= bus.mem_din;
        if (bus.en_drd) bus.mem_dout <= mem[bus.mem_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Expected grant per cycle as {b_gnt, a_gnt}; read returns as {b_rv, a_rv, data}.
    logic [1:0] exp_gnt_q [$];
    logic [9:0] exp_rd_q  [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_gnt_q.size() > 0) begin
                chk("gnt", {30'd0, bus.b_gnt, bus.a_gnt}, {30'd0, exp_gnt_q.pop_front()});
            end else if (bus.a_gnt || bus.b_gnt) begin
                chk("gnt_unexpected", {30'd0, bus.b_gnt, bus.a_gnt}, 32'd0);
            end
            if (bus.a_rvalid || bus.b_rvalid) begin
                if (exp_rd_q.size() > 0) begin
                    chk("rdata", {22'd0, bus.b_rvalid, bus.a_rvalid,
                                  bus.a_rvalid ? bus.a_rdata : bus.b_rdata},
                        {22'd0, exp_rd_q.pop_front()});
                end else begin
                    chk("rvalid_unexpected", {30'd0, bus.b_rvalid, bus.a_rvalid}, 32'd0);
                end
            end
        end
    end

    // One cycle of stimulus; called at posedge+1, returns at next posedge+1.
    task automatic cyc(input logic ar, input logic aw, input logic al,
                       input logic [7:0] aa, input logic [7:0] ad,
                       input logic br, input logic bw, input logic bl,
                       input logic [7:0] ba, input logic [7:0] bd,
                       input logic [1:0] eg);
        bus.a_req = ar; bus.a_we = aw; bus.a_lock = al; bus.a_addr = aa; bus.a_wdata = ad;
        bus.b_req = br; bus.b_we = bw; bus.b_lock = bl; bus.b_addr = ba; bus.b_wdata = bd;
        exp_gnt_q.push_back(eg);
        @(posedge clk);
        #1;
    endtask

    task automatic rst_seq();
        rst_n = 1'b0;
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_lock = 1'b1;
        bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_lock = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_gnt",    {30'd0, bus.b_gnt, bus.a_gnt}, 32'd0);
            chk("rst_en",     {30'd0, bus.en_drd, bus.en_dwr}, 32'd0);
            chk("rst_rvalid", {30'd0, bus.b_rvalid, bus.a_rvalid}, 32'd0);
        end
        bus.a_req = 1'b0; bus.b_req = 1'b0; bus.a_lock = 1'b0; bus.b_lock = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst_n = 1'b0;
        bus.a_req = 0; bus.a_we = 0; bus.a_lock = 0; bus.a_addr = 0; bus.a_wdata = 0;
        bus.b_req = 0; bus.b_we = 0; bus.b_lock = 0; bus.b_addr = 0; bus.b_wdata = 0;
        @(posedge clk);
        #1;
        rst_seq();

        // Single read after a B write.
        cyc(0,0,0,8'h00,8'h00, 1,1,0,8'h10,8'h5A, 2'b10);
        cyc(1,0,0,8'h10,8'h00, 0,0,0,8'h00,8'h00, 2'b01);
        exp_rd_q.push_back({2'b01, 8'h5A});
        cyc(0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 2'b00);
        // Preload for the following reads.
        cyc(1,1,0,8'h20,8'h11, 0,0,0,8'h00,8'h00, 2'b01);
        cyc(0,0,0,8'h00,8'h00, 1,1,0,8'h30,8'h22, 2'b10);

        // Contention from reset: strict alternation starting with A.
        rst_seq();
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) exp_rd_q.push_back({2'b01, 8'h11});
            else            exp_rd_q.push_back({2'b10, 8'h22});
            cyc(1,0,0,8'h20,8'h00, 1,0,0,8'h30,8'h00, (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        cyc(0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 2'b00);

        // Lock bound: A,A,A,A then B, then A.
        rst_seq();
        for (int i = 0; i < 6; i++) begin
            if (i == 4) exp_rd_q.push_back({2'b10, 8'h22});
            else        exp_rd_q.push_back({2'b01, 8'h11});
            cyc(1,0,1,8'h20,8'h00, 1,0,0,8'h30,8'h00, (i == 4) ? 2'b10 : 2'b01);
        end
        // Lock release: A still owns this cycle, B wins the next, then A.
        exp_rd_q.push_back({2'b01, 8'h11});
        cyc(1,0,0,8'h20,8'h00, 1,0,0,8'h30,8'h00, 2'b01);
        exp_rd_q.push_back({2'b10, 8'h22});
        cyc(1,0,0,8'h20,8'h00, 1,0,0,8'h30,8'h00, 2'b10);
        exp_rd_q.push_back({2'b01, 8'h11});
        cyc(1,0,0,8'h20,8'h00, 1,0,0,8'h30,8'h00, 2'b01);
        cyc(0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 2'b00);

        // Read-after-write on consecutive cycles.
        cyc(1,1,0,8'hFF,8'hC3, 0,0,0,8'h00,8'h00, 2'b01);
        cyc(0,0,0,8'h00,8'h00, 1,0,0,8'hFF,8'h00, 2'b10);
        exp_rd_q.push_back({2'b10, 8'hC3});
        cyc(0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 2'b00);

        // Reset mid-read: the A read is dropped, and A regains first priority.
        cyc(1,0,0,8'h20,8'h00, 0,0,0,8'h00,8'h00, 2'b01);
        rst_seq();
        exp_rd_q.push_back({2'b01, 8'h11});
        cyc(1,0,0,8'h20,8'h00, 1,0,0,8'h30,8'h00, 2'b01);
        cyc(0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 2'b00);
        cyc(0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 2'b00);

        chk("drain_gnt", exp_gnt_q.size(), 32'd0);
        chk("drain_rd",  exp_rd_q.size(),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
